// File: rtl/regfile_rd_arbiter_pkg.sv
// Shared types and default sizes for the register-file read arbiter.
package regfile_arb_pkg;
   localparam int RF_NENT  = 4;
   localparam int RF_WIDTH = 4;
   localparam int RF_AW    = $clog2(RF_NENT);

   typedef logic [RF_AW-1:0]    rf_addr_t;
   typedef logic [RF_WIDTH-1:0] rf_data_t;
   typedef enum logic {REQ_A, REQ_B} req_id_t;
endpackage

// File: rtl/regfile_rd_arbiter_if.sv
// Write port plus two read requester channels (request and response handshakes).
interface regfile_rd_arbiter_if #(
   parameter int NENT  = 4,
   parameter int WIDTH = 4
);
   localparam int AW = $clog2(NENT);

   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;

   logic             a_req_valid;
   logic [AW-1:0]    a_req_addr;
   logic             a_req_ready;
   logic             a_rsp_valid;
   logic [WIDTH-1:0] a_rsp_data;
   logic             a_rsp_ready;

   logic             b_req_valid;
   logic [AW-1:0]    b_req_addr;
   logic             b_req_ready;
   logic             b_rsp_valid;
   logic [WIDTH-1:0] b_rsp_data;
   logic             b_rsp_ready;

   modport master (
      output wr_en, wr_addr, wr_data,
      output a_req_valid, a_req_addr, a_rsp_ready,
      output b_req_valid, b_req_addr, b_rsp_ready,
      input  a_req_ready, a_rsp_valid, a_rsp_data,
      input  b_req_ready, b_rsp_valid, b_rsp_data
   );

   modport slave (
      input  wr_en, wr_addr, wr_data,
      input  a_req_valid, a_req_addr, a_rsp_ready,
      input  b_req_valid, b_req_addr, b_rsp_ready,
      output a_req_ready, a_rsp_valid, a_rsp_data,
      output b_req_ready, b_rsp_valid, b_rsp_data
   );
endinterface

// File: rtl/regfile_rd_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: one-hot grant and the priority to hold next.
module rr_arb2
   import regfile_arb_pkg::*;
(
   input  logic [1:0] elig,
   input  req_id_t    pri,
   output logic [1:0] gnt,
   output req_id_t    pri_nxt
);

   always_comb begin
      gnt     = 2'b00;
      pri_nxt = pri;
      unique case (elig)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (pri == REQ_A) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
      // The loser of this cycle's grant gets priority next time.
      if (gnt[0])      pri_nxt = REQ_B;
      else if (gnt[1]) pri_nxt = REQ_A;
   end

endmodule

// File: rtl/regfile_rd_arbiter.sv
// Register array with one read port shared round-robin between requesters A and B.
// Optional build macro SV_RDARB_XIDLE_EN drives rsp_data to X while rsp_valid is low.
module regfile_rd_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int NENT  = RF_NENT,
   parameter int WIDTH = RF_WIDTH
) (
   input logic                clk,
   input logic                rst_n,
   regfile_rd_arbiter_if.slave bus
);

   localparam int AW = $clog2(NENT);

   logic [WIDTH-1:0] mem [NENT];

   logic [1:0]       req_vld;
   logic [1:0]       rsp_rdy;
   logic [AW-1:0]    req_addr   [2];
   logic [1:0]       elig;
   logic [1:0]       gnt;
   req_id_t          pri;
   req_id_t          pri_nxt;
   logic [WIDTH-1:0] rd_data_p0 [2];
   logic [1:0]       rsp_vld_p1;
   logic [WIDTH-1:0] rsp_data_p1 [2];

   assign req_vld     = {bus.b_req_valid, bus.a_req_valid};
   assign rsp_rdy     = {bus.b_rsp_ready, bus.a_rsp_ready};
   assign req_addr[0] = bus.a_req_addr;
   assign req_addr[1] = bus.b_req_addr;

   // A slot accepts a new read when empty or being drained this cycle.
   assign elig = req_vld & (~rsp_vld_p1 | rsp_rdy);

   rr_arb2 u_arb (
      .elig    (elig),
      .pri     (pri),
      .gnt     (gnt),
      .pri_nxt (pri_nxt)
   );

   assign bus.a_req_ready = gnt[0];
   assign bus.b_req_ready = gnt[1];

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         rd_data_p0[i] = (bus.wr_en && (bus.wr_addr == req_addr[i])) ? bus.wr_data
                                                                       : mem[req_addr[i]];
      end
   end

   // ---- grant cycle -> response slot ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NENT; i++) mem[i] <= '0;
         rsp_vld_p1     <= 2'b00;
         rsp_data_p1[0] <= '0;
         rsp_data_p1[1] <= '0;
         pri            <= REQ_A;
      end else begin
         if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
         pri <= pri_nxt;
         for (int i = 0; i < 2; i++) begin
            if (gnt[i]) begin
               rsp_vld_p1[i]  <= 1'b1;
               rsp_data_p1[i] <= rd_data_p0[i];
            end else if (rsp_rdy[i]) begin
               rsp_vld_p1[i]  <= 1'b0;
            end
         end
      end
   end

   assign bus.a_rsp_valid = rsp_vld_p1[0];
   assign bus.b_rsp_valid = rsp_vld_p1[1];

`ifdef SV_RDARB_XIDLE_EN
   assign bus.a_rsp_data = rsp_vld_p1[0] ? rsp_data_p1[0] : {WIDTH{1'bx}};
   assign bus.b_rsp_data = rsp_vld_p1[1] ? rsp_data_p1[1] : {WIDTH{1'bx}};
`else
   assign bus.a_rsp_data = rsp_data_p1[0];
   assign bus.b_rsp_data = rsp_data_p1[1];
`endif

endmodule

// File: tb/tb_regfile_rd_arbiter.sv
// Directed bench for regfile_rd_arbiter: reset, round-robin, stall, bypass, mid-run reset.
module tb_regfile_rd_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   int   nchk = 0;
   int   nerr = 0;
   logic [3:0] idle_exp;
   logic [3:0] hold_exp;

   always #5 clk = ~clk;

   regfile_rd_arbiter_if #(.NENT(4), .WIDTH(4)) bus ();

   regfile_rd_arbiter #(.NENT(4), .WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [3:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      step();
      bus.wr_en   = 1'b0;
   endtask

   initial begin
`ifdef SV_RDARB_XIDLE_EN
      idle_exp = 4'bxxxx;
      hold_exp = 4'bxxxx;
`else
      idle_exp = 4'h0;
      hold_exp = 4'hA;
`endif
      rst_n           = 1'b0;
      bus.wr_en       = 1'b0;
      bus.wr_addr     = '0;
      bus.wr_data     = '0;
      bus.a_req_valid = 1'b0;
      bus.a_req_addr  = '0;
      bus.a_rsp_ready = 1'b0;
      bus.b_req_valid = 1'b0;
      bus.b_req_addr  = '0;
      bus.b_rsp_ready = 1'b0;

      // Reset state
      #12;
      chk("rst_a_vld",  bus.a_rsp_valid, 1'b0);
      chk("rst_b_vld",  bus.b_rsp_valid, 1'b0);
      chk("rst_a_data", bus.a_rsp_data,  idle_exp);
      chk("rst_b_data", bus.b_rsp_data,  idle_exp);
      step();
      rst_n = 1'b1;
      step();

      // 1. Writes then a single read from A
      wr(2'd0, 4'h5);
      wr(2'd1, 4'hA);
      wr(2'd2, 4'h3);
      wr(2'd3, 4'hF);
      chk("idle_a_rdy", bus.a_req_ready, 1'b0);
      bus.a_req_valid = 1'b1;
      bus.a_req_addr  = 2'd1;
      #1;
      chk("t1_a_rdy", bus.a_req_ready, 1'b1);
      step();
      bus.a_req_valid = 1'b0;
      chk("t1_a_vld",  bus.a_rsp_valid, 1'b1);
      chk("t1_a_data", bus.a_rsp_data,  4'hA);
      bus.a_rsp_ready = 1'b1;
      step();
      chk("t1_drain_vld",  bus.a_rsp_valid, 1'b0);
      chk("t1_drain_data", bus.a_rsp_data,  hold_exp);

      // 2. Both requesting from reset priority: grants alternate A,B,A,B
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      step();
      wr(2'd0, 4'h5);
      wr(2'd3, 4'hF);
      bus.a_req_valid = 1'b1;
      bus.a_req_addr  = 2'd0;
      bus.b_req_valid = 1'b1;
      bus.b_req_addr  = 2'd3;
      bus.a_rsp_ready = 1'b1;
      bus.b_rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         logic exp_a;
         exp_a = ((k % 2) == 0);
         #1;
         chk($sformatf("t2_a_rdy%0d", k), bus.a_req_ready, exp_a);
         chk($sformatf("t2_b_rdy%0d", k), bus.b_req_ready, !exp_a);
         step();
         chk($sformatf("t2_a_vld%0d", k), bus.a_rsp_valid, exp_a);
         chk($sformatf("t2_b_vld%0d", k), bus.b_rsp_valid, !exp_a);
         if (exp_a) chk($sformatf("t2_a_data%0d", k), bus.a_rsp_data, 4'h5);
         else       chk($sformatf("t2_b_data%0d", k), bus.b_rsp_data, 4'hF);
      end

      // 3. A stalls its response; B gets every grant, A's data stays put
      bus.a_rsp_ready = 1'b0;
      #1;
      chk("t3_a_rdy_first", bus.a_req_ready, 1'b1);
      step();
      chk("t3_a_vld",  bus.a_rsp_valid, 1'b1);
      chk("t3_a_data", bus.a_rsp_data,  4'h5);
      chk("t3_b_vld",  bus.b_rsp_valid, 1'b0);
      for (int j = 0; j < 3; j++) begin
         if (j == 0) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 2'd0;
            bus.wr_data = 4'h9;
         end
         #1;
         chk($sformatf("t3_a_rdy%0d", j), bus.a_req_ready, 1'b0);
         chk($sformatf("t3_b_rdy%0d", j), bus.b_req_ready, 1'b1);
         step();
         bus.wr_en = 1'b0;
         chk($sformatf("t3_hold%0d", j),   bus.a_rsp_data,  4'h5);
         chk($sformatf("t3_b_vld%0d", j),  bus.b_rsp_valid, 1'b1);
         chk($sformatf("t3_b_data%0d", j), bus.b_rsp_data,  4'hF);
      end

      // 4. Write bypass into a granted B read of the same entry
      bus.b_req_addr = 2'd2;
      bus.wr_en      = 1'b1;
      bus.wr_addr    = 2'd2;
      bus.wr_data    = 4'h7;
      #1;
      chk("t4_b_rdy", bus.b_req_ready, 1'b1);
      step();
      bus.wr_en = 1'b0;
      chk("t4_bypass", bus.b_rsp_data, 4'h7);
      step();
      chk("t4_mem2", bus.b_rsp_data, 4'h7);
      bus.b_req_addr = 2'd0;
      step();
      chk("t4_mem0", bus.b_rsp_data, 4'h9);

      // 5. Reset while both slots hold responses
      bus.a_req_valid = 1'b0;
      bus.b_req_valid = 1'b0;
      bus.b_rsp_ready = 1'b0;
      #1;
      chk("t5_pre_a", bus.a_rsp_valid, 1'b1);
      chk("t5_pre_b", bus.b_rsp_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_a_vld",  bus.a_rsp_valid, 1'b0);
      chk("t5_rst_b_vld",  bus.b_rsp_valid, 1'b0);
      chk("t5_rst_a_data", bus.a_rsp_data,  idle_exp);
      chk("t5_rst_b_data", bus.b_rsp_data,  idle_exp);
      #1;
      rst_n = 1'b1;
      step();
      chk("t5_post_a_vld", bus.a_rsp_valid, 1'b0);
      bus.a_rsp_ready = 1'b1;
      bus.b_rsp_ready = 1'b1;
      bus.a_req_valid = 1'b1;
      for (int e = 0; e < 4; e++) begin
         bus.a_req_addr = e[1:0];
         step();
         chk($sformatf("t5_vld%0d", e),   bus.a_rsp_valid, 1'b1);
         chk($sformatf("t5_entry%0d", e), bus.a_rsp_data,  4'h0);
      end
      bus.a_req_valid = 1'b0;
      step();
      chk("t6_idle_vld",  bus.a_rsp_valid, 1'b0);
      chk("t6_idle_data", bus.a_rsp_data,  idle_exp);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
